// File: rtl/display_capture_pkg.sv
// Shared definitions for the LED panel capture path and its driver-side encoder.
//   flush_state_e : flush FSM encoding
//   pix_idx()     : LSB of segment s / channel c inside a packed pixel word
package display_capture_pkg;

  typedef enum logic [1:0] {
    FL_IDLE   = 2'd0,
    FL_STREAM = 2'd1,
    FL_DONE   = 2'd2
  } flush_state_e;

  function automatic int unsigned pix_idx(input int unsigned seg,
                                          input int unsigned ch,
                                          input int unsigned bitdepth);
    return (seg * 3 + ch) * bitdepth;
  endfunction

endpackage

// File: rtl/display_capture_sync.sv
// Brings the panel pins into the clk domain.
//   clk, rst     : system clock, async active-high reset
//   oclk_i/lat_i/oe_i : asynchronous panel strobes (2-flop synchronised)
//   rgb_i, row_i : panel data, delayed to line up with the edge pulses
//   *_rise_o / oe_fall_o : one-clk registered edge pulses
//   rgb_o, row_o : data aligned with the edge pulses
module display_capture_sync #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned ROW_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              oclk_i,
  input  logic              lat_i,
  input  logic              oe_i,
  input  logic [DATA_W-1:0] rgb_i,
  input  logic [ROW_W-1:0]  row_i,
  output logic              oclk_rise_o,
  output logic              lat_rise_o,
  output logic              oe_fall_o,
  output logic [DATA_W-1:0] rgb_o,
  output logic [ROW_W-1:0]  row_o
);

  // control bits packed as {oe, lat, oclk}
  logic [2:0]        ctl_s1_q, ctl_s2_q, ctl_s3_q;
  logic [DATA_W-1:0] rgb_s1_q, rgb_s2_q, rgb_q;
  logic [ROW_W-1:0]  row_s1_q, row_s2_q, row_q;
  logic              oclk_rise_q, lat_rise_q, oe_fall_q;

  // Synchroniser stages, stage-2 vs stage-3 edge detect, matched data delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_s1_q    <= '0;
      ctl_s2_q    <= '0;
      ctl_s3_q    <= '0;
      rgb_s1_q    <= '0;
      rgb_s2_q    <= '0;
      rgb_q       <= '0;
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      row_q       <= '0;
      oclk_rise_q <= 1'b0;
      lat_rise_q  <= 1'b0;
      oe_fall_q   <= 1'b0;
    end else begin
      ctl_s1_q    <= {oe_i, lat_i, oclk_i};
      ctl_s2_q    <= ctl_s1_q;
      ctl_s3_q    <= ctl_s2_q;
      rgb_s1_q    <= rgb_i;
      rgb_s2_q    <= rgb_s1_q;
      rgb_q       <= rgb_s2_q;
      row_s1_q    <= row_i;
      row_s2_q    <= row_s1_q;
      row_q       <= row_s2_q;
      oclk_rise_q <= ctl_s2_q[0] & ~ctl_s3_q[0];
      lat_rise_q  <= ctl_s2_q[1] & ~ctl_s3_q[1];
      oe_fall_q   <= ~ctl_s2_q[2] & ctl_s3_q[2];
    end
  end

  assign oclk_rise_o = oclk_rise_q;
  assign lat_rise_o  = lat_rise_q;
  assign oe_fall_o   = oe_fall_q;
  assign rgb_o       = rgb_q;
  assign row_o       = row_q;

endmodule

// File: rtl/display_capture.sv
// Receiving end of a latched row/column LED panel: shifts column bits in,
// accumulates per-pixel PWM on-windows for the current row, and on every row
// change streams the recovered intensities of the finished row as writes.
//   clk, rst        : system clock, async active-high reset
//   rgb/oclk/lat/oe/row : panel pins (asynchronous to clk)
//   wr_en/wr_row/wr_column/wr_pixel : pixel write port
//   frame_done      : pulse after the last pixel of the last row
//   overrun         : sticky, row change arrived during a flush
//   misalign        : sticky, latch after a shift count other than columns
module display_capture
  import display_capture_pkg::*;
#(
  parameter int unsigned segments = 1,
  parameter int unsigned rows     = 8,
  parameter int unsigned columns  = 32,
  parameter int unsigned bitdepth = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [3*segments-1:0]          rgb,
  input  logic                           oclk,
  input  logic                           lat,
  input  logic                           oe,
  input  logic [$clog2(rows)-1:0]        row,
  output logic                           wr_en,
  output logic [$clog2(rows)-1:0]        wr_row,
  output logic [$clog2(columns)-1:0]     wr_column,
  output logic [bitdepth*3*segments-1:0] wr_pixel,
  output logic                           frame_done,
  output logic                           overrun,
  output logic                           misalign
);

  localparam int unsigned CH_N  = 3 * segments;
  localparam int unsigned PIX_W = bitdepth * CH_N;
  localparam int unsigned ROW_W = $clog2(rows);
  localparam int unsigned COL_W = $clog2(columns);
  localparam int unsigned BIT_W = $clog2(columns + 1);
  localparam logic [bitdepth-1:0] CNT_MAX = '1;

  logic             oclk_rise, lat_rise, oe_fall;
  logic [CH_N-1:0]  rgb_s;
  logic [ROW_W-1:0] row_s;

  display_capture_sync #(
    .DATA_W (CH_N),
    .ROW_W  (ROW_W)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .oclk_i      (oclk),
    .lat_i       (lat),
    .oe_i        (oe),
    .rgb_i       (rgb),
    .row_i       (row),
    .oclk_rise_o (oclk_rise),
    .lat_rise_o  (lat_rise),
    .oe_fall_o   (oe_fall),
    .rgb_o       (rgb_s),
    .row_o       (row_s)
  );

  logic [columns-1:0][CH_N-1:0]  shift_q, latch_q;
  logic [columns-1:0][PIX_W-1:0] cnt_q, cnt_inc_c, snap_q;
  logic [ROW_W-1:0]              cur_row_q, snap_row_q;
  logic [BIT_W-1:0]              bit_cnt_q;
  logic                          misalign_q, overrun_q;
  logic                          row_chg_c;

  flush_state_e     state_q, state_d;
  logic             wr_en_q, wr_en_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d, next_col_c;
  logic [PIX_W-1:0] wr_pixel_q, wr_pixel_d;
  logic             frame_done_q, frame_done_d;

  assign row_chg_c  = lat_rise & (row_s != cur_row_q);
  assign next_col_c = wr_col_q + 1'b1;

  // Counters after this cycle's oe fall; a snapshot taken now includes it
  always_comb begin
    cnt_inc_c = cnt_q;
    if (oe_fall) begin
      for (int unsigned c = 0; c < columns; c++) begin
        for (int unsigned s = 0; s < segments; s++) begin
          for (int unsigned ch = 0; ch < 3; ch++) begin
            if (latch_q[c][s*3+ch] &&
                cnt_q[c][pix_idx(s, ch, bitdepth) +: bitdepth] != CNT_MAX) begin
              cnt_inc_c[c][pix_idx(s, ch, bitdepth) +: bitdepth] =
                cnt_q[c][pix_idx(s, ch, bitdepth) +: bitdepth] + 1'b1;
            end
          end
        end
      end
    end
  end

  // Shift / latch / accumulate / snapshot datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      latch_q    <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      snap_row_q <= '0;
      cur_row_q  <= '0;
      bit_cnt_q  <= '0;
      misalign_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (oclk_rise) begin
        shift_q <= {rgb_s, shift_q[columns-1:1]};
        if (bit_cnt_q != BIT_W'(columns)) bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (lat_rise) begin
        if (bit_cnt_q != BIT_W'(columns)) misalign_q <= 1'b1;
        latch_q   <= shift_q;
        bit_cnt_q <= '0;
        cur_row_q <= row_s;
      end
      if (row_chg_c) begin
        snap_q     <= cnt_inc_c;
        snap_row_q <= cur_row_q;
        cnt_q      <= '0;
        if (state_q != FL_IDLE) overrun_q <= 1'b1;
      end else begin
        cnt_q <= cnt_inc_c;
      end
    end
  end

  // Flush FSM state and registered write-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FL_IDLE;
      wr_en_q      <= 1'b0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      wr_pixel_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      wr_pixel_q   <= wr_pixel_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state and next-output; a row change always (re)starts at column 0
  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    wr_pixel_d   = wr_pixel_q;
    frame_done_d = 1'b0;
    case (state_q)
      FL_STREAM: begin
        if (wr_col_q == COL_W'(columns - 1)) begin
          state_d      = FL_DONE;
          frame_done_d = (snap_row_q == ROW_W'(rows - 1));
        end else begin
          wr_en_d    = 1'b1;
          wr_col_d   = next_col_c;
          wr_pixel_d = snap_q[next_col_c];
        end
      end
      FL_DONE: state_d = FL_IDLE;
      default: state_d = FL_IDLE;
    endcase
    if (row_chg_c) begin
      state_d      = FL_STREAM;
      wr_en_d      = 1'b1;
      wr_row_d     = cur_row_q;
      wr_col_d     = '0;
      wr_pixel_d   = cnt_inc_c[0];
      frame_done_d = 1'b0;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_row     = wr_row_q;
  assign wr_column  = wr_col_q;
  assign wr_pixel   = wr_pixel_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_display_capture.sv
// Self-checking bench for display_capture (segments=1, rows=2, columns=4, bitdepth=4).
module tb_display_capture;

  localparam int unsigned SEG  = 1;
  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 4;
  localparam int unsigned BD   = 4;
  localparam int unsigned CH   = 3 * SEG;
  localparam int unsigned PW   = BD * CH;
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CW   = $clog2(COLS);
  localparam int          MAXC = (1 << BD) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] rgb;
  logic          oclk, lat, oe;
  logic [RW-1:0] row;
  logic          wr_en;
  logic [RW-1:0] wr_row;
  logic [CW-1:0] wr_column;
  logic [PW-1:0] wr_pixel;
  logic          frame_done, overrun, misalign;

  always #5 clk = ~clk;

  display_capture #(
    .segments (SEG),
    .rows     (ROWS),
    .columns  (COLS),
    .bitdepth (BD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rgb        (rgb),
    .oclk       (oclk),
    .lat        (lat),
    .oe         (oe),
    .row        (row),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_column  (wr_column),
    .wr_pixel   (wr_pixel),
    .frame_done (frame_done),
    .overrun    (overrun),
    .misalign   (misalign)
  );

  typedef struct packed {
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [PW-1:0] p;
  } wr_t;

  int  total = 0;
  int  bad   = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  fd_seen = 0, fd_exp = 0, fd_misplaced = 0;
  bit  prev_last = 1'b0;

  // Reference panel model: plain integer arrays
  int m_shift[COLS][CH];
  int m_latch[COLS][CH];
  int m_cnt[COLS][CH];
  int m_row, m_bits;
  bit m_mis;

  // Write-port monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        wr_t e;
        e.r = wr_row;
        e.c = wr_column;
        e.p = wr_pixel;
        got_q.push_back(e);
      end
      if (frame_done) begin
        fd_seen++;
        if (!prev_last) fd_misplaced++;
      end
      prev_last = wr_en && (wr_column == CW'(COLS - 1));
    end else begin
      prev_last = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < CH; k++) begin
        m_shift[c][k] = 0;
        m_latch[c][k] = 0;
        m_cnt[c][k]   = 0;
      end
    m_row  = 0;
    m_bits = 0;
    m_mis  = 1'b0;
  endtask

  function automatic logic [PW-1:0] m_pix(input int c);
    logic [PW-1:0] p = '0;
    for (int k = 0; k < CH; k++) p = p | (PW'(m_cnt[c][k]) << (k * BD));
    return p;
  endfunction

  task automatic m_oe_fall();
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < CH; k++)
        if (m_latch[c][k] != 0 && m_cnt[c][k] < MAXC) m_cnt[c][k]++;
  endtask

  // keep: how many writes of this flush survive before the next event cuts it
  task automatic m_lat(input int r, input int keep);
    if (m_bits != COLS) m_mis = 1'b1;
    if (r != m_row) begin
      for (int c = 0; c < keep; c++) begin
        wr_t e;
        e.r = RW'(m_row);
        e.c = CW'(c);
        e.p = m_pix(c);
        exp_q.push_back(e);
      end
      if (keep == COLS && m_row == ROWS - 1) fd_exp++;
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < CH; k++) m_cnt[c][k] = 0;
    end
    for (int c = 0; c < COLS; c++)
      for (int k = 0; k < CH; k++) m_latch[c][k] = m_shift[c][k];
    m_bits = 0;
    m_row  = r;
  endtask

  task automatic shift_in(input logic [CH-1:0] bits);
    rgb = bits;
    wait_cyc(3);
    oclk = 1'b1;
    wait_cyc(3);
    oclk = 1'b0;
    wait_cyc(1);
    for (int c = 0; c < COLS - 1; c++)
      for (int k = 0; k < CH; k++) m_shift[c][k] = m_shift[c+1][k];
    for (int k = 0; k < CH; k++) m_shift[COLS-1][k] = int'(bits[k]);
    if (m_bits < COLS) m_bits++;
  endtask

  task automatic oe_pulse();
    oe = 1'b1;
    wait_cyc(3);
    oe = 1'b0;
    wait_cyc(3);
    m_oe_fall();
  endtask

  // with_oe: oe (already high) falls in the same cycle as lat rises
  task automatic do_lat(input int r, input bit with_oe);
    row = RW'(r);
    if (with_oe) begin
      oe = 1'b0;
      m_oe_fall();
    end
    lat = 1'b1;
    m_lat(r, COLS);
    wait_cyc(3);
    lat = 1'b0;
    wait_cyc(3);
  endtask

  task automatic check_flush(input string tag);
    wait_cyc(12);
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      wr_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_row"}, 64'(g.r), 64'(e.r));
      chk({tag, "_col"}, 64'(g.c), 64'(e.c));
      chk({tag, "_pix"}, 64'(g.p), 64'(e.p));
    end
    got_q.delete();
    exp_q.delete();
    chk({tag, "_fd_cnt"}, 64'(fd_seen), 64'(fd_exp));
    chk({tag, "_fd_pos"}, 64'(fd_misplaced), 64'(0));
  endtask

  initial begin
    bit hit;
    rst = 1'b1; rgb = '0; oclk = 1'b0; lat = 1'b0; oe = 1'b0; row = '0;
    m_reset();
    wait_cyc(3);
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_pixel", 64'(wr_pixel), 64'(0));
    chk("rst_fd", 64'(frame_done), 64'(0));
    chk("rst_ovr", 64'(overrun), 64'(0));
    chk("rst_mis", 64'(misalign), 64'(0));
    rst = 1'b0;
    wait_cyc(2);

    // Row 0: r = 1,0,1,1 with three display windows
    shift_in(3'b001); shift_in(3'b000); shift_in(3'b001); shift_in(3'b001);
    do_lat(0, 1'b0);
    repeat (3) oe_pulse();
    // Row 1 data all ones, then change -> flush row 0 (r=3,0,3,3)
    repeat (4) shift_in(3'b111);
    do_lat(1, 1'b0);
    check_flush("row0");
    chk("row0_fd_zero", 64'(fd_seen), 64'(0));

    // Row 1: 20 windows saturate, change to row 0 -> frame_done
    repeat (20) oe_pulse();
    repeat (4) shift_in(3'(($urandom) & 7));
    do_lat(0, 1'b0);
    check_flush("row1_sat");
    chk("mis_clean", 64'(misalign), 64'(m_mis));
    chk("ovr_clean", 64'(overrun), 64'(0));

    // Short shift count before lat
    repeat (3) shift_in(3'b101);
    do_lat(0, 1'b0);
    chk("mis_set", 64'(misalign), 64'(m_mis));

    // oe fall coincident with row-change lat belongs to the old row
    repeat (4) shift_in(3'b111);
    do_lat(0, 1'b0);
    repeat (2) oe_pulse();
    repeat (4) shift_in(3'b010);
    oe = 1'b1;
    wait_cyc(3);
    do_lat(1, 1'b1);
    check_flush("same_cyc");

    // Two row changes 2 clk apart
    row = 1'b0; lat = 1'b1; m_lat(0, 2);
    wait_cyc(1);
    lat = 1'b0;
    wait_cyc(1);
    row = 1'b1; lat = 1'b1; m_lat(1, COLS);
    wait_cyc(1);
    lat = 1'b0;
    wait_cyc(3);
    chk("ovr_set", 64'(overrun), 64'(1));
    check_flush("overrun");
    chk("mis_sticky", 64'(misalign), 64'(1));

    // Reset while streaming column 2
    repeat (4) shift_in(3'b110);
    do_lat(1, 1'b0);
    repeat (2) oe_pulse();
    row = 1'b0; lat = 1'b1; m_lat(0, 2);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (wr_en && wr_column == CW'(2)) hit = 1'b1;
    end
    chk("rst_col2_seen", 64'(hit), 64'(1));
    rst = 1'b1;
    lat = 1'b0;
    #1;
    chk("rst_async_wr_en", 64'(wr_en), 64'(0));
    m_reset();
    wait_cyc(3);
    chk("rst_mid_mis", 64'(misalign), 64'(0));
    chk("rst_mid_ovr", 64'(overrun), 64'(0));
    rst = 1'b0;
    check_flush("rst_partial");

    // First change after reset flushes row 0 with zero counts
    repeat (4) shift_in(3'(($urandom) & 7));
    do_lat(1, 1'b0);
    check_flush("post_rst");

    // Randomized rows
    for (int it = 0; it < 6; it++) begin
      int n;
      repeat (4) shift_in(3'($urandom_range(0, 7)));
      do_lat(int'($urandom_range(0, 1)), 1'b0);
      n = int'($urandom_range(0, 18));
      repeat (n) oe_pulse();
      check_flush("rand");
    end
    repeat (4) shift_in(3'($urandom_range(0, 7)));
    do_lat((m_row == 0) ? 1 : 0, 1'b0);
    check_flush("rand_last");
    chk("rand_mis", 64'(misalign), 64'(m_mis));
    chk("rand_ovr", 64'(overrun), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
